// File: rtl/aes_input_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_input_packer_pkg
// Purpose  : Shared AES ingress types and constants. Holds the output packet
//            handed to the first-round stage and the FIFO entry format.
// Revision : 1.0 - initial release
// ============================================================================
package aes_input_packer_pkg;

   localparam int AES_WORD_W          = 32;
   localparam int AES_WORDS_PER_BLOCK = 4;
   localparam int AES_BLOCK_W         = AES_WORD_W * AES_WORDS_PER_BLOCK;

   localparam logic AES_MODE_ENC = 1'b0;
   localparam logic AES_MODE_DEC = 1'b1;

   // Packet issued into the first-round stage: {valid, data, en_de}
   typedef struct packed {
      logic                   valid;
      logic [AES_BLOCK_W-1:0] data;
      logic                   en_de;
   } out_packet_t;

   // One buffered block: {data, en_de}
   typedef struct packed {
      logic [AES_BLOCK_W-1:0] data;
      logic                   en_de;
   } block_entry_t;

endpackage
`default_nettype wire

// File: rtl/aes_block_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_fifo
// Purpose  : DEPTH-entry synchronous FIFO of complete AES blocks. Full and
//            empty are decided by the occupancy count, so the pointers may
//            freely wrap modulo DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_fifo
   import aes_input_packer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  block_entry_t     wr_entry,
   input  logic             pop,
   input  logic             flush,
   output block_entry_t     rd_entry,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   block_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO or a pop from an empty one is ignored so that no
   // entry can ever be overwritten or read past.
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign rd_entry = mem[rd_ptr];

   // Pointer and occupancy tracking; flush wins over push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since they are only read when valid
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : aes_input_packer
// Purpose  : Host ingress for the AES pipeline. Packs four 32-bit words
//            (most-significant first) into a tagged 128-bit block, buffers
//            complete blocks, and issues one block per cycle into the
//            first-round stage unless held off during key loading.
// Revision : 1.0 - initial release
// ============================================================================
module aes_input_packer
   import aes_input_packer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [AES_WORD_W-1:0] in_word,
   input  logic                  in_en_de,
   input  logic                  flush,
   input  logic                  hold,
   output out_packet_t           data_out,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  busy
);

   localparam int               WCNT_W    = $clog2(AES_WORDS_PER_BLOCK);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(AES_WORDS_PER_BLOCK - 1);
   localparam int               ASM_W     = AES_BLOCK_W - AES_WORD_W;

   logic [WCNT_W-1:0] word_cnt;
   logic [ASM_W-1:0]  asm_q;
   logic              en_de_q;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   block_entry_t      wr_entry;
   block_entry_t      head;

   // in_ready depends only on registered state and flush, never on hold or
   // on a pop in the same cycle, so the host sees a clean timing path.
   assign in_ready = !flush && ((word_cnt != LAST_WORD) || !fifo_full);
   assign accept   = in_valid && in_ready;
   assign push     = accept && (word_cnt == LAST_WORD);
   assign pop      = !fifo_empty && !hold && !flush;

   // The final word completes the block directly from the input bus
   assign wr_entry.data  = {asm_q, in_word};
   assign wr_entry.en_de = en_de_q;

   assign busy = (word_cnt != '0) || (fifo_count != '0) || data_out.valid;

   // Word assembler: shift in accepted words and latch the mode on word 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         asm_q    <= '0;
         en_de_q  <= AES_MODE_ENC;
      end else if (flush) begin
         word_cnt <= '0;
         asm_q    <= '0;
         en_de_q  <= AES_MODE_ENC;
      end else if (accept) begin
         asm_q    <= {asm_q[ASM_W-AES_WORD_W-1:0], in_word};
         word_cnt <= word_cnt + WCNT_W'(1);
         if (word_cnt == '0) begin
            en_de_q <= in_en_de;
         end
      end
   end

   aes_block_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .flush    (flush),
      .rd_entry (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Output register: carries a block for exactly one cycle, zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
      end else if (pop) begin
         data_out.valid <= 1'b1;
         data_out.data  <= head.data;
         data_out.en_de <= head.en_de;
      end else begin
         data_out <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_input_packer
// Purpose  : Directed self-checking bench for aes_input_packer (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_input_packer;
   import aes_input_packer_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_word;
   logic             in_en_de;
   logic             flush;
   logic             hold;
   out_packet_t      data_out;
   logic [CNT_W-1:0] fifo_count;
   logic             busy;

   int checks = 0;
   int errors = 0;

   aes_input_packer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .in_en_de   (in_en_de),
      .flush      (flush),
      .hold       (hold),
      .data_out   (data_out),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] wd(input int k, input int i);
      return 32'hB000_0000 | 32'(k << 8) | 32'(i);
   endfunction

   function automatic logic [127:0] blk(input int k);
      return {wd(k, 0), wd(k, 1), wd(k, 2), wd(k, 3)};
   endfunction

   function automatic logic ende(input int k);
      return 1'(k % 2);
   endfunction

   function automatic logic [129:0] pkt(input logic [127:0] d, input logic e);
      return {1'b1, d, e};
   endfunction

   // Present one word and wait (bounded) until it is accepted
   task automatic send_word(input logic [31:0] w, input logic e);
      int n;
      in_valid = 1'b1;
      in_word  = w;
      in_en_de = e;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_wait", {129'b0, in_ready}, 130'd1);
      tick();
   endtask

   // Full block; words 1-3 carry the opposite mode to prove it is ignored
   task automatic send_block(input int k);
      for (int i = 0; i < 4; i++) begin
         send_word(wd(k, i), (i == 0) ? ende(k) : ~ende(k));
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_word  = '0;
      in_en_de = 1'b0;
      flush    = 1'b0;
      hold     = 1'b0;
      tick();
      tick();

      // ---- reset state
      check("rst_data_out", data_out, 130'd0);
      check("rst_fifo_count", {127'b0, fifo_count}, 130'd0);
      check("rst_busy", {129'b0, busy}, 130'd0);
      check("rst_in_ready", {129'b0, in_ready}, 130'd1);
      rst_n = 1'b1;
      tick();

      // ---- single encrypt block
      send_word(32'h00112233, 1'b0);
      send_word(32'h44556677, 1'b0);
      send_word(32'h8899aabb, 1'b0);
      send_word(32'hccddeeff, 1'b0);
      in_valid = 1'b0;
      check("enc_count_after_push", {127'b0, fifo_count}, 130'd1);
      check("enc_no_bypass", data_out, 130'd0);
      tick();
      check("enc_packet", data_out, pkt(128'h00112233445566778899aabbccddeeff, 1'b0));
      check("enc_busy_while_valid", {129'b0, busy}, 130'd1);
      tick();
      check("enc_valid_drops", data_out, 130'd0);
      check("enc_busy_idle", {129'b0, busy}, 130'd0);

      // ---- decrypt tag latched from word 0 only
      send_word(32'h01020304, 1'b1);
      send_word(32'h05060708, 1'b0);
      send_word(32'h090a0b0c, 1'b0);
      send_word(32'h0d0e0f10, 1'b0);
      in_valid = 1'b0;
      tick();
      check("dec_packet", data_out, pkt(128'h0102030405060708090a0b0c0d0e0f10, 1'b1));
      tick();

      // ---- backpressure: hold while five blocks arrive
      hold = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         send_block(k);
      end
      check("bp_full_count", {127'b0, fifo_count}, 130'd4);
      send_word(wd(5, 0), ende(5));
      send_word(wd(5, 1), ~ende(5));
      send_word(wd(5, 2), ~ende(5));
      in_valid = 1'b1;
      in_word  = wd(5, 3);
      in_en_de = ~ende(5);
      #1;
      check("bp_ready_low_word3", {129'b0, in_ready}, 130'd0);
      tick();
      check("bp_stalled_count", {127'b0, fifo_count}, 130'd4);
      check("bp_held_output", data_out, 130'd0);
      hold = 1'b0;
      tick();
      check("bp_pkt1", data_out, pkt(blk(1), ende(1)));
      check("bp_count_after_pop", {127'b0, fifo_count}, 130'd3);
      check("bp_ready_back", {129'b0, in_ready}, 130'd1);
      tick();
      in_valid = 1'b0;
      check("bp_pkt2", data_out, pkt(blk(2), ende(2)));
      check("bp_push_pop_count", {127'b0, fifo_count}, 130'd3);
      tick();
      check("bp_pkt3", data_out, pkt(blk(3), ende(3)));
      tick();
      check("bp_pkt4", data_out, pkt(blk(4), ende(4)));
      tick();
      check("bp_pkt5", data_out, pkt(blk(5), ende(5)));
      check("bp_count_empty", {127'b0, fifo_count}, 130'd0);
      tick();
      check("bp_idle", data_out, 130'd0);
      check("bp_busy_idle", {129'b0, busy}, 130'd0);

      // ---- hold pulsed for two cycles during issue
      hold = 1'b1;
      send_block(6);
      send_block(7);
      send_block(8);
      check("hm_count", {127'b0, fifo_count}, 130'd3);
      hold = 1'b0;
      tick();
      check("hm_pkt6", data_out, pkt(blk(6), ende(6)));
      hold = 1'b1;
      tick();
      check("hm_gap1", data_out, 130'd0);
      check("hm_retained", {127'b0, fifo_count}, 130'd2);
      tick();
      check("hm_gap2", data_out, 130'd0);
      hold = 1'b0;
      tick();
      check("hm_pkt7", data_out, pkt(blk(7), ende(7)));
      tick();
      check("hm_pkt8", data_out, pkt(blk(8), ende(8)));
      tick();
      check("hm_idle", data_out, 130'd0);

      // ---- flush with two blocks and a partial third buffered
      hold = 1'b1;
      send_block(9);
      send_block(10);
      send_word(wd(11, 0), ende(11));
      send_word(wd(11, 1), ~ende(11));
      in_valid = 1'b0;
      check("fl_pre_count", {127'b0, fifo_count}, 130'd2);
      hold     = 1'b0;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_word  = 32'hdeadbeef;
      #1;
      check("fl_ready_low", {129'b0, in_ready}, 130'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_count", {127'b0, fifo_count}, 130'd0);
      check("fl_data_out", data_out, 130'd0);
      check("fl_busy", {129'b0, busy}, 130'd0);
      tick();
      check("fl_nothing_issued", data_out, 130'd0);
      send_block(12);
      tick();
      check("fl_new_block", data_out, pkt(blk(12), ende(12)));
      tick();

      // ---- asynchronous reset mid-block
      hold = 1'b1;
      send_block(13);
      send_word(wd(14, 0), ende(14));
      send_word(wd(14, 1), ~ende(14));
      send_word(wd(14, 2), ~ende(14));
      in_valid = 1'b0;
      check("ar_pre_count", {127'b0, fifo_count}, 130'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_count", {127'b0, fifo_count}, 130'd0);
      check("ar_data_out", data_out, 130'd0);
      check("ar_busy", {129'b0, busy}, 130'd0);
      check("ar_in_ready", {129'b0, in_ready}, 130'd1);
      tick();
      rst_n = 1'b1;
      hold  = 1'b0;
      tick();
      send_block(15);
      check("ar_fresh_count", {127'b0, fifo_count}, 130'd1);
      tick();
      check("ar_fresh_block", data_out, pkt(blk(15), ende(15)));
      tick();
      check("ar_idle", data_out, 130'd0);
      check("ar_busy_idle", {129'b0, busy}, 130'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_input_packer.md
Name: aes_input_packer

Overview:
Host-facing ingress stage directly upstream of the AES first-round stage. It accepts 32-bit words over a valid/ready handshake and assembles four words into a 128-bit block tagged with an encrypt/decrypt flag. Completed blocks are buffered in a small FIFO. Each buffered block is issued as one out_packet_t per cycle into the pipeline, which has no backpressure. Issue can be held off while a key or inverse key is being loaded.

Parameters:
DEPTH, 4, number of 128-bit block entries in the FIFO; power of two, at least 2.
CNT_W, $clog2(DEPTH)+1, width of fifo_count.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  host word valid
in_ready  output  1  packer can accept a word this cycle
in_word  input  32  host data word; the most-significant word of the block arrives first
in_en_de  input  1  0 = encrypt, 1 = decrypt; sampled only with word 0 of a block
flush  input  1  synchronous clear of the partial block, the FIFO and the output register
hold  input  1  suppresses issue, e.g. while set_key or set_inv_key is active
data_out  output  130  out_packet_t {valid, data[127:0], en_de}, registered, feeds the first-round stage
fifo_count  output  CNT_W  number of complete blocks buffered
busy  output  1  high when word_cnt!=0, fifo_count!=0 or data_out.valid

Behaviour:
- Reset values: data_out = 0, fifo_count = 0, word_cnt = 0, assembly register = 0, FIFO pointers = 0. busy = 0; in_ready = 1 while flush is low.
- Word handshake: a word is accepted on a clk edge where in_valid && in_ready.
- in_ready = !flush && (word_cnt != 3 || fifo_count < DEPTH). It is purely state-based, with no combinational path from hold or from a pop.
- Assembly: on accept, asm <= {asm[95:0], in_word} and word_cnt increments modulo 4.
  - On word 0, the block's en_de is latched from in_en_de; changes to in_en_de on words 1-3 are ignored.
  - On word 3, the FIFO receives {asm[95:0], in_word, latched en_de} and word_cnt wraps to 0.
- Issue: on each edge where fifo_count != 0 && !hold && !flush:
  - pop the head entry;
  - data_out <= {1'b1, entry.data, entry.en_de}.
- Otherwise data_out <= 0, so valid=0, data=0 and en_de=0. Data is never left stale while valid is low.
- Latency: a block whose last word is accepted at edge E is written to the FIFO at E. data_out.valid rises at E+1 if hold is low. There is no bypass around the FIFO.
- Throughput: one block per cycle while the FIFO is non-empty and hold is low. A host supplying one word per cycle therefore leaves data_out.valid high one cycle in four.
- Simultaneous push and pop on the same edge: fifo_count is unchanged and both operations complete.
- Full FIFO (fifo_count == DEPTH):
  - words 0-2 of the next block are still accepted;
  - word 3 stalls (in_ready = 0) until a pop has reduced fifo_count;
  - no entry is ever overwritten.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by fifo_count only.
- hold:
  - when asserted, issue stops at the next edge and FIFO contents are retained;
  - assembly and push continue;
  - on deassertion, issue resumes in order with no block lost or duplicated.
- flush:
  - at the edge where flush=1, word_cnt, the partial block, the FIFO and data_out are cleared;
  - flush has priority over push and pop;
  - a word presented in the same cycle is not accepted, since in_ready=0.
- Reset mid-operation: all state returns to the reset values immediately; partial blocks are discarded.
- The block exposes no error outputs. Overflow is impossible by construction.

Decomposition:
- out_packet_t already lives in sysdef.svh and is reused unchanged: a packed struct {valid, data[127:0], en_de}, 130 bits.
- Add to the same shared header:
  - localparams AES_WORD_W=32, AES_WORDS_PER_BLOCK=4, AES_MODE_ENC=1'b0, AES_MODE_DEC=1'b1;
  - typedef block_entry_t {data[127:0], en_de}.
- One sub-module: aes_block_fifo, a parameterised DEPTH x block_entry_t synchronous FIFO with push, pop, flush, count, full and empty. The packer top holds the word assembler, the issue logic and the output register.

Test Plan:
- Single encrypt block: words 00112233, 44556677, 8899aabb, ccddeeff with in_en_de=0 on word 0 -> one edge after the last accept, data_out = {1, 00112233445566778899aabbccddeeff, 0}; valid=0 on the next cycle; busy returns to 0.
- Decrypt tag latch: word 0 sent with in_en_de=1, then in_en_de=0 on words 1-3 -> issued packet has en_de=1.
- Backpressure: hold=1 while 5 blocks are streamed with DEPTH=4 -> fifo_count=4; in_ready drops on word 3 of block 5. Release hold -> 5 packets issue in order, each valid for one cycle, with no loss.
- Hold mid-stream: 3 blocks buffered, hold pulsed for 2 cycles during issue -> data_out.valid low for exactly those 2 cycles; remaining blocks issue afterwards in order.
- Flush: after 2 complete blocks plus 2 words of a third, assert flush for 1 cycle -> next cycle fifo_count=0, data_out.valid=0, word_cnt=0. A new 4-word block then issues correctly.
- Async reset mid-block: after 3 words of a block, drop rst_n -> outputs go to 0 immediately. After reset release, a fresh 4-word block is assembled from word 0 and no stale words appear in it.
